// File: rtl/eop_gen_pkg.sv
// Shared definitions for the eop_gen stream framer: FSM state encoding and default sizing.
package eop_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } eop_gen_state_t;

  localparam int unsigned EOP_GEN_TIMEOUT_DEF = 256;
  localparam int unsigned EOP_GEN_LEN_W_DEF   = 16;

endpackage

// File: rtl/eop_timeout_cnt.sv
// Saturating idle counter with synchronous clear; hit is registered and high once the count equals MAX.
// MAX = 0 disables the counter: hit never asserts.
module eop_timeout_cnt #(
  parameter int unsigned MAX = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic hit
);

  localparam int unsigned CNT_W = (MAX < 2) ? 1 : $clog2(MAX + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;

  // Clear wins over enable; the count sticks at MAX.
  always_comb begin
    cnt_nxt = cnt_q;
    if (clear) begin
      cnt_nxt = '0;
    end else if (en && (cnt_q != CNT_W'(MAX))) begin
      cnt_nxt = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      hit   <= 1'b0;
    end else begin
      cnt_q <= cnt_nxt;
      hit   <= (MAX != 0) && (cnt_nxt == CNT_W'(MAX));
    end
  end

endmodule

// File: rtl/eop_gen.sv
// SOP-marked to LAST-marked stream framer with a one-beat look-ahead hold register.
// Optional beat-length output is built only when EOP_GEN_LEN_EN is defined.
module eop_gen
  import eop_gen_pkg::*;
#(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = EOP_GEN_TIMEOUT_DEF,
  parameter int unsigned LEN_W   = EOP_GEN_LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_sop_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o,
  output logic [LEN_W-1:0]  len_o,
  output logic              sop_err_o
);

  eop_gen_state_t    state_q;
  logic [DATA_W-1:0] hold_q;
  logic              to_hit;
  logic              close;
  logic              load;

  assign close = (state_q == HOLD) && (flush_i || to_hit);
  assign load  = in_valid_i && in_ready_o;

  // Handshake outputs; in HOLD they follow the look-ahead beat combinationally.
  always_comb begin
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    out_last_o  = 1'b0;
    case (state_q)
      IDLE: in_ready_o = 1'b1;
      HOLD: begin
        if (!close) begin
          out_valid_o = in_valid_i;
          out_last_o  = in_sop_i;
          in_ready_o  = out_ready_i;
        end
      end
      DRAIN: begin
        out_valid_o = 1'b1;
        out_last_o  = 1'b1;
      end
      default: ;
    endcase
    if (!rst_n) begin
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      out_last_o  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sop_err_o <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            state_q <= HOLD;
            if (!in_sop_i) sop_err_o <= 1'b1;
          end
        end
        HOLD:    if (close) state_q <= DRAIN;
        DRAIN:   if (out_ready_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Hold register content is don't-care until the first load.
  always_ff @(posedge clk) begin
    if (load) hold_q <= in_data_i;
  end

  assign out_data_o = hold_q;

  eop_timeout_cnt #(
    .MAX (TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (load || close),
    .en    ((state_q == HOLD) && !in_valid_i),
    .hit   (to_hit)
  );

`ifdef EOP_GEN_LEN_EN
  logic [LEN_W-1:0] beat_cnt_q;
  logic             out_hs;

  assign out_hs = out_valid_o && out_ready_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
    end else if (out_hs) begin
      if (out_last_o) begin
        beat_cnt_q <= '0;
      end else if (beat_cnt_q != '1) begin
        beat_cnt_q <= beat_cnt_q + LEN_W'(1);
      end
    end
  end

  // Saturating +1 so a maximal-length packet reports all-ones instead of wrapping.
  always_comb begin
    len_o = '0;
    if (out_valid_o && out_last_o) begin
      len_o = (beat_cnt_q == '1) ? beat_cnt_q : beat_cnt_q + LEN_W'(1);
    end
  end
`else
  assign len_o = '0;
`endif

endmodule

// File: tb/tb_eop_gen.sv
// Directed bench for eop_gen: a per-cycle vector table plus hand-written timeout, missing-sop and reset sequences.
module tb_eop_gen;

  localparam int unsigned DW = 16;
  localparam int unsigned LW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_sop, flush, out_valid, out_ready, out_last, sop_err;
  logic [DW-1:0] in_data, out_data;
  logic [LW-1:0] len;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  eop_gen #(.DATA_W(DW), .TIMEOUT(4), .LEN_W(LW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_sop_i    (in_sop),
    .flush_i     (flush),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .len_o       (len),
    .sop_err_o   (sop_err)
  );

  typedef struct {
    logic          iv, isop, fl, ordy;
    logic [DW-1:0] d;
    logic          ev, el, er;
    logic [DW-1:0] ed;
    logic [LW-1:0] elen;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(logic iv, logic isop, logic [DW-1:0] d, logic fl, logic ordy,
                               logic ev, logic el, logic er, logic [DW-1:0] ed, logic [LW-1:0] elen);
    vec_t v;
    v.iv = iv; v.isop = isop; v.d = d; v.fl = fl; v.ordy = ordy;
    v.ev = ev; v.el = el; v.er = er; v.ed = ed; v.elen = elen;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic isop, input logic [DW-1:0] d,
                       input logic fl, input logic ordy);
    in_valid = iv; in_sop = isop; in_data = d; flush = fl; out_ready = ordy;
  endtask

  // Advance to 1ns after the next rising edge, where inputs are changed.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic chk_len(input string nm, input logic [LW-1:0] exp);
`ifdef EOP_GEN_LEN_EN
    chk(nm, 64'(len), 64'(exp));
`else
    chk(nm, 64'(len), 64'(exp & '0));
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
    step();
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_sop_err", 64'(sop_err), 64'd0);
    chk("rst_len", 64'(len), 64'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 64'(in_ready), 64'd1);
    step();

    //            iv sop data      fl ordy  ev el er  exp_data  len
    // Two packets back-to-back, then flush.
    tbl.push_back(mkv(1, 1, 16'hA000, 0, 1,  0, 0, 1, 16'h0000, 0));
    tbl.push_back(mkv(1, 0, 16'hA001, 0, 1,  1, 0, 1, 16'hA000, 0));
    tbl.push_back(mkv(1, 0, 16'hA002, 0, 1,  1, 0, 1, 16'hA001, 0));
    tbl.push_back(mkv(1, 1, 16'hB000, 0, 1,  1, 1, 1, 16'hA002, 3));
    tbl.push_back(mkv(1, 0, 16'hB001, 0, 1,  1, 0, 1, 16'hB000, 0));
    tbl.push_back(mkv(0, 0, 16'h0000, 1, 1,  0, 0, 0, 16'h0000, 0));
    tbl.push_back(mkv(0, 0, 16'h0000, 0, 1,  1, 1, 0, 16'hB001, 2));
    tbl.push_back(mkv(0, 0, 16'h0000, 0, 1,  0, 0, 1, 16'h0000, 0));
    // Single-beat packets.
    tbl.push_back(mkv(1, 1, 16'hC000, 0, 1,  0, 0, 1, 16'h0000, 0));
    tbl.push_back(mkv(1, 1, 16'hC001, 0, 1,  1, 1, 1, 16'hC000, 1));
    tbl.push_back(mkv(1, 1, 16'hC002, 0, 1,  1, 1, 1, 16'hC001, 1));
    tbl.push_back(mkv(0, 0, 16'h0000, 1, 1,  0, 0, 0, 16'h0000, 0));
    tbl.push_back(mkv(0, 0, 16'h0000, 0, 1,  1, 1, 0, 16'hC002, 1));
    tbl.push_back(mkv(0, 0, 16'h0000, 0, 1,  0, 0, 1, 16'h0000, 0));
    // Six-beat packet under toggling backpressure, closed by the next sop.
    tbl.push_back(mkv(1, 1, 16'hD000, 0, 1,  0, 0, 1, 16'h0000, 0));
    tbl.push_back(mkv(1, 0, 16'hD001, 0, 0,  1, 0, 0, 16'hD000, 0));
    tbl.push_back(mkv(1, 0, 16'hD001, 0, 1,  1, 0, 1, 16'hD000, 0));
    tbl.push_back(mkv(1, 0, 16'hD002, 0, 0,  1, 0, 0, 16'hD001, 0));
    tbl.push_back(mkv(1, 0, 16'hD002, 0, 1,  1, 0, 1, 16'hD001, 0));
    tbl.push_back(mkv(1, 0, 16'hD003, 0, 0,  1, 0, 0, 16'hD002, 0));
    tbl.push_back(mkv(1, 0, 16'hD003, 0, 1,  1, 0, 1, 16'hD002, 0));
    tbl.push_back(mkv(1, 0, 16'hD004, 0, 0,  1, 0, 0, 16'hD003, 0));
    tbl.push_back(mkv(1, 0, 16'hD004, 0, 1,  1, 0, 1, 16'hD003, 0));
    tbl.push_back(mkv(1, 0, 16'hD005, 0, 0,  1, 0, 0, 16'hD004, 0));
    tbl.push_back(mkv(1, 0, 16'hD005, 0, 1,  1, 0, 1, 16'hD004, 0));
    tbl.push_back(mkv(1, 1, 16'hE000, 0, 0,  1, 1, 0, 16'hD005, 6));
    tbl.push_back(mkv(1, 1, 16'hE000, 0, 1,  1, 1, 1, 16'hD005, 6));
    tbl.push_back(mkv(0, 0, 16'h0000, 1, 0,  0, 0, 0, 16'h0000, 0));
    tbl.push_back(mkv(0, 0, 16'h0000, 0, 0,  1, 1, 0, 16'hE000, 1));
    tbl.push_back(mkv(0, 0, 16'h0000, 0, 1,  1, 1, 0, 16'hE000, 1));
    tbl.push_back(mkv(0, 0, 16'h0000, 0, 1,  0, 0, 1, 16'h0000, 0));
    // Flush in IDLE has no effect.
    tbl.push_back(mkv(0, 0, 16'h0000, 1, 1,  0, 0, 1, 16'h0000, 0));
    tbl.push_back(mkv(0, 0, 16'h0000, 0, 1,  0, 0, 1, 16'h0000, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].iv, tbl[i].isop, tbl[i].d, tbl[i].fl, tbl[i].ordy);
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'(tbl[i].ev));
      chk($sformatf("v%0d_ready", i), 64'(in_ready), 64'(tbl[i].er));
      chk($sformatf("v%0d_sop_err", i), 64'(sop_err), 64'd0);
      if (tbl[i].ev) begin
        chk($sformatf("v%0d_last", i), 64'(out_last), 64'(tbl[i].el));
        chk($sformatf("v%0d_data", i), 64'(out_data), 64'(tbl[i].ed));
        if (tbl[i].el) chk_len($sformatf("v%0d_len", i), tbl[i].elen);
      end
      step();
    end

    // Idle timeout: valid rises on the 5th edge after the accepting edge.
    drive(1'b1, 1'b1, 16'h7700, 1'b0, 1'b1);
    @(negedge clk);
    chk("to_accept", 64'(in_ready), 64'd1);
    step();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("to_wait%0d", k), 64'(out_valid), 64'd0);
      step();
    end
    out_ready = 1'b0;
    @(negedge clk);
    chk("to_valid", 64'(out_valid), 64'd1);
    chk("to_last", 64'(out_last), 64'd1);
    chk("to_data", 64'(out_data), 64'h7700);
    chk("to_drain_ready", 64'(in_ready), 64'd0);
    step();
    @(negedge clk);
    chk("to_hold_valid", 64'(out_valid), 64'd1);
    chk("to_hold_data", 64'(out_data), 64'h7700);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("to_release_valid", 64'(out_valid), 64'd1);
    step();
    @(negedge clk);
    chk("to_idle_valid", 64'(out_valid), 64'd0);
    chk("to_idle_ready", 64'(in_ready), 64'd1);
    step();

    // Missing sop on the first beat after reset.
    do_reset();
    drive(1'b1, 1'b0, 16'h5100, 1'b0, 1'b1);
    @(negedge clk);
    chk("ms_err_pre", 64'(sop_err), 64'd0);
    step();
    drive(1'b1, 1'b0, 16'h5101, 1'b0, 1'b1);
    @(negedge clk);
    chk("ms_err_set", 64'(sop_err), 64'd1);
    chk("ms_b0_valid", 64'(out_valid), 64'd1);
    chk("ms_b0_last", 64'(out_last), 64'd0);
    chk("ms_b0_data", 64'(out_data), 64'h5100);
    step();
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
    @(negedge clk);
    chk("ms_close_valid", 64'(out_valid), 64'd0);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("ms_b1_last", 64'(out_last), 64'd1);
    chk("ms_b1_data", 64'(out_data), 64'h5101);
    step();
    @(negedge clk);
    chk("ms_err_sticky", 64'(sop_err), 64'd1);
    chk("ms_idle_valid", 64'(out_valid), 64'd0);
    step();

    // Reset while a beat is held: nothing stale may come out afterwards.
    drive(1'b1, 1'b1, 16'h9900, 1'b0, 1'b1);
    step();
    drive(1'b1, 1'b0, 16'h9901, 1'b0, 1'b1);
    @(negedge clk);
    chk("rm_r0_data", 64'(out_data), 64'h9900);
    step();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    chk("rm_rst_valid", 64'(out_valid), 64'd0);
    chk("rm_rst_ready", 64'(in_ready), 64'd0);
    step();
    @(negedge clk);
    chk("rm_err_clr", 64'(sop_err), 64'd0);
    step();
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 16'h4400, 1'b0, 1'b1);
    @(negedge clk);
    chk("rm_idle_valid", 64'(out_valid), 64'd0);
    chk("rm_idle_ready", 64'(in_ready), 64'd1);
    step();
    drive(1'b1, 1'b1, 16'h4401, 1'b0, 1'b1);
    @(negedge clk);
    chk("rm_n0_valid", 64'(out_valid), 64'd1);
    chk("rm_n0_data", 64'(out_data), 64'h4400);
    chk("rm_n0_last", 64'(out_last), 64'd1);
    chk_len("rm_n0_len", 16'd1);
    step();
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("rm_n1_data", 64'(out_data), 64'h4401);
    chk("rm_n1_last", 64'(out_last), 64'd1);
    chk("rm_err_still_clr", 64'(sop_err), 64'd0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
